apb_slave_bank: RTL

//  APB peripheral model that sits directly downstream of the AHB-to-APB bridge. It consumes the

---
 rtl/apb_slave_bank.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_bank.sv
// Purpose : APB peripheral model with NUM_SLV register banks, protocol monitor, sticky error flag, transfer counters.
// Latency : read data registered on the edge ending SETUP (valid through ACCESS); write lands on the edge ending ACCESS.
// Backpressure: none; no pready, so every valid transfer completes in exactly two cycles.
module apb_slave_bank #(
  parameter int NUM_SLV = 3,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic [NUM_SLV-1:0] psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        pr_data,
  output logic               prot_err,
  output logic [CNT_W-1:0]   wr_cnt,
  output logic [CNT_W-1:0]   rd_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_mem [NUM_SLV][DEPTH];
  logic [NUM_SLV-1:0]   r_psel;
  logic [KW-1:0]        r_k;
  logic [31:0]          r_addr;
  logic                 r_write;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [CNT_W-1:0]     r_wr_cnt;
  logic [CNT_W-1:0]     r_rd_cnt;

  logic                 w_sel_ok;
  logic                 w_multi;
  logic [KW-1:0]        w_k;
  logic [AW-1:0]        w_idx;
  logic                 w_capture;
  logic                 w_rd_go;
  logic                 w_complete;
  logic                 w_err_set;

  assign w_sel_ok = $onehot(psel);
  assign w_multi  = (psel != '0) && !w_sel_ok;
  // Word index always comes from the captured address so SETUP and ACCESS agree.
  assign w_idx    = r_addr[2 +: AW];

  // Encode the one-hot select into a bank index.
  always_comb begin
    w_k = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (psel[i]) w_k = KW'(i);
    end
  end

  // Protocol monitor: next state plus capture/read/complete/error strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_rd_go     = 1'b0;
    w_complete  = 1'b0;
    w_err_set   = 1'b0;
    if (w_multi) begin
      // Multi-hot select overrides everything: abort, flag, no side effects.
      w_state_nxt = ST_IDLE;
      w_err_set   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (penable) begin
            w_err_set = 1'b1;
          end else if (w_sel_ok) begin
            w_state_nxt = ST_SETUP;
            w_capture   = 1'b1;
          end
        end
        ST_SETUP: begin
          if (penable && (psel == r_psel) && (paddr == r_addr) && (pwrite == r_write)) begin
            w_state_nxt = ST_ACCESS;
            w_rd_go     = !r_write;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_set   = 1'b1;
          end
        end
        ST_ACCESS: begin
          w_complete = 1'b1;
          if (w_sel_ok && !penable) begin
            w_state_nxt = ST_SETUP;
            w_capture   = 1'b1;
          end else if (psel == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_err_set   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Capture the transfer attributes at the setup phase for the match check.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_psel  <= '0;
      r_k     <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else if (w_capture) begin
      r_psel  <= psel;
      r_k     <= w_k;
      r_addr  <= paddr;
      r_write <= pwrite;
    end
  end

  // Bank storage: written only when a valid write transfer completes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int b = 0; b < NUM_SLV; b++) begin
        for (int w = 0; w < DEPTH; w++) begin
          r_mem[b][w] <= '0;
        end
      end
    end else if (w_complete && r_write) begin
      r_mem[r_k][w_idx] <= pwdata;
    end
  end

  // Read data register, sticky error and wrapping transfer counters.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_rd_go)               r_rdata  <= r_mem[r_k][w_idx];
      if (w_err_set)             r_err    <= 1'b1;
      if (w_complete && r_write)  r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      if (w_complete && !r_write) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
    end
  end

  assign pr_data  = r_rdata;
  assign prot_err = r_err;
  assign wr_cnt   = r_wr_cnt;
  assign rd_cnt   = r_rd_cnt;

endmodule
